// File: rtl/lcd_phy_pkg.sv
// Shared types and instruction-word bit positions for the HD44780 pin driver.
package lcd_phy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E_HIGH,
    E_HOLD,
    BSY_SETUP,
    BSY_E_HIGH,
    BSY_HOLD
  } phy_state_e;

  localparam int unsigned RS_BIT   = 9;
  localparam int unsigned RW_BIT   = 8;
  localparam int unsigned BUSY_BIT = 7;

endpackage

// File: rtl/lcd_phase_timer.sv
// Down-counter timing one bus phase; done while the count sits at zero.
module lcd_phase_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_c
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/lcd_phy.sv
// HD44780 8-bit parallel pin sequencer: issues one instruction with a
// programmable E strobe, then polls the busy flag until ready or timeout.
module lcd_phy #(
  parameter int unsigned DATA_WIDTH             = 8,
  parameter int unsigned INSTR_WIDTH            = 10,
  parameter int unsigned PRESCALER_WIDTH        = 16,
  parameter int unsigned CHECK_BUSY_ERROR_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       phy_enable_i,
  input  logic [PRESCALER_WIDTH-1:0] prescaler_10ns_i,
  input  logic [INSTR_WIDTH-1:0]     lcd_instr_i,
  input  logic                       valid_instr_i,
  output logic                       phy_read_o,
  output logic [DATA_WIDTH-1:0]      lcd_rdata_o,
  output logic                       busy_error_o,
  output logic                       lcd_rs_o,
  output logic                       lcd_rw_o,
  output logic                       lcd_e_o,
  output logic [DATA_WIDTH-1:0]      lcd_db_o,
  output logic                       lcd_db_oe_o,
  input  logic [DATA_WIDTH-1:0]      lcd_db_i
);

  import lcd_phy_pkg::*;

  localparam int unsigned PW = PRESCALER_WIDTH;
  localparam int unsigned CW = CHECK_BUSY_ERROR_WIDTH;
  localparam logic [CW-1:0] POLL_MAX = '1;

  phy_state_e             state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [CW-1:0]          poll_q, poll_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   rs_q, rs_d;
  logic                   rw_q, rw_d;
  logic                   e_q, e_d;
  logic [DATA_WIDTH-1:0]  db_q, db_d;
  logic                   oe_q, oe_d;

  logic          accept_c;
  logic          phase_done_c;
  logic          phase_load_c;
  logic [PW-1:0] phase_len_c;

  assign accept_c     = rst_ni && (state_q == IDLE) && phy_enable_i && valid_instr_i;
  assign phase_load_c = (state_d != state_q);
  // A prescaler of zero behaves as one cycle per phase.
  assign phase_len_c  = (prescaler_10ns_i == '0) ? '0 : prescaler_10ns_i - PW'(1);

  lcd_phase_timer #(
    .WIDTH (PW)
  ) u_phase_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (phase_load_c),
    .load_val_i (phase_len_c),
    .done_c     (phase_done_c)
  );

  // Next-state, instruction latch, busy-poll bookkeeping and read capture.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    poll_d  = poll_q;
    busy_d  = busy_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = SETUP;
          instr_d = lcd_instr_i;
          poll_d  = '0;
          err_d   = 1'b0;
        end
      end
      SETUP: if (phase_done_c) state_d = E_HIGH;
      E_HIGH: begin
        if (phase_done_c) begin
          if (instr_q[RW_BIT]) rdata_d = lcd_db_i;
          state_d = E_HOLD;
        end
      end
      E_HOLD:    if (phase_done_c) state_d = BSY_SETUP;
      BSY_SETUP: if (phase_done_c) state_d = BSY_E_HIGH;
      BSY_E_HIGH: begin
        if (phase_done_c) begin
          busy_d  = lcd_db_i[BUSY_BIT];
          poll_d  = poll_q + CW'(1);
          state_d = BSY_HOLD;
        end
      end
      BSY_HOLD: begin
        // poll_q counts completed polls at this point.
        if (phase_done_c) begin
          if (!busy_q) begin
            state_d = IDLE;
          end else if (poll_q == POLL_MAX) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = BSY_SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin values follow the state being entered so they change on the same edge.
  always_comb begin
    rs_d = rs_q;
    rw_d = rw_q;
    e_d  = e_q;
    db_d = db_q;
    oe_d = oe_q;
    unique case (state_d)
      SETUP, E_HIGH, E_HOLD: begin
        rs_d = instr_d[RS_BIT];
        rw_d = instr_d[RW_BIT];
        db_d = instr_d[DATA_WIDTH-1:0];
        oe_d = ~instr_d[RW_BIT];
        e_d  = (state_d == E_HIGH);
      end
      BSY_SETUP, BSY_E_HIGH, BSY_HOLD: begin
        rs_d = 1'b0;
        rw_d = 1'b1;
        oe_d = 1'b0;
        e_d  = (state_d == BSY_E_HIGH);
      end
      default: begin
        rs_d = 1'b0;
        rw_d = 1'b1;
        oe_d = 1'b0;
        e_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      instr_q <= '0;
      poll_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b1;
      e_q     <= 1'b0;
      db_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      poll_q  <= poll_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      e_q     <= e_d;
      db_q    <= db_d;
      oe_q    <= oe_d;
    end
  end

  assign phy_read_o   = accept_c;
  assign lcd_rdata_o  = rdata_q;
  assign busy_error_o = err_q;
  assign lcd_rs_o     = rs_q;
  assign lcd_rw_o     = rw_q;
  assign lcd_e_o      = e_q;
  assign lcd_db_o     = db_q;
  assign lcd_db_oe_o  = oe_q;

endmodule
